i2s_transmitter: RTL and testbench

I2S_TRANSMITTER -- requirements
Module: i2s_transmitter

---
 rtl/i2s_transmitter.sv | 92 +++++++++
 tb/tb_i2s_transmitter.sv | 100 ++++++++++
 2 files changed

// File: rtl/i2s_transmitter.sv
// i2s_transmitter: I2S serializer with a one-pair holding buffer and mute-on-underrun framing
module i2s_transmitter #(
    parameter int AUDIO_BIT_WIDTH = 24,
    parameter int CLOCKS_PER_BIT  = 6,
    parameter int SLOT_WIDTH      = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [AUDIO_BIT_WIDTH-1:0] sample_left,
    input  logic [AUDIO_BIT_WIDTH-1:0] sample_right,
    input  logic                       sample_valid,
    output logic                       sample_ready,
    output logic                       bclk,
    output logic                       lrclk,
    output logic                       sdata,
    output logic                       frame_start,
    output logic                       underrun
);
    localparam int CW = $clog2(CLOCKS_PER_BIT);
    localparam int BW = $clog2(2 * SLOT_WIDTH);
    localparam logic [CW-1:0] C_LAST = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_HALF = CW'(CLOCKS_PER_BIT / 2);
    localparam logic [BW-1:0] B_LAST = BW'(2 * SLOT_WIDTH - 1);
    localparam logic [BW-1:0] B_SLOT = BW'(SLOT_WIDTH);
    localparam logic [BW-1:0] B_AW   = BW'(AUDIO_BIT_WIDTH);

    logic [CW-1:0]              r_c;
    logic [BW-1:0]              r_b;
    logic                       r_bclk, r_lrclk, r_sdata, r_fs, r_ur, r_full;
    logic [AUDIO_BIT_WIDTH-1:0] r_bufl, r_bufr, r_fl, r_fr;

    logic [CW-1:0]              w_c_n;
    logic [BW-1:0]              w_b_n, w_p;
    logic [AUDIO_BIT_WIDTH-1:0] w_ch, w_sh;
    logic                       w_right, w_sd, w_bnd, w_bnd_n, w_acc, w_full_n;

    assign w_c_n    = (r_c == C_LAST) ? '0 : r_c + 1'b1;
    assign w_b_n    = (r_c != C_LAST) ? r_b : (r_b == B_LAST) ? '0 : r_b + 1'b1;
    assign w_right  = w_b_n >= B_SLOT;
    assign w_p      = w_right ? w_b_n - B_SLOT : w_b_n;
    assign w_ch     = w_right ? r_fr : r_fl;
    // MSB of the channel shifted left by p-1 is bit (AUDIO_BIT_WIDTH - p)
    assign w_sh     = w_ch << (w_p - 1'b1);
    assign w_sd     = (w_p != '0) && (w_p <= B_AW) && w_sh[AUDIO_BIT_WIDTH-1];
    assign w_bnd    = (r_c == C_LAST) && (r_b == B_LAST);
    assign w_bnd_n  = (w_c_n == C_LAST) && (w_b_n == B_LAST);
    assign w_acc    = sample_valid && !r_full;
    // A boundary empties the buffer before any coincident accept refills it
    assign w_full_n = w_acc || (r_full && !w_bnd);

    assign sample_ready = !r_full;
    assign bclk         = r_bclk;
    assign lrclk        = r_lrclk;
    assign sdata        = r_sdata;
    assign frame_start  = r_fs;
    assign underrun     = r_ur;

    // Counters, buffer and frame registers; outputs register the next cycle's values
    always_ff @(posedge clock) begin
        if (reset) begin
            r_c     <= '0;
            r_b     <= '0;
            r_bclk  <= 1'b0;
            r_lrclk <= 1'b0;
            r_sdata <= 1'b0;
            r_fs    <= 1'b0;
            r_ur    <= 1'b0;
            r_full  <= 1'b0;
            r_bufl  <= '0;
            r_bufr  <= '0;
            r_fl    <= '0;
            r_fr    <= '0;
        end else begin
            r_c     <= w_c_n;
            r_b     <= w_b_n;
            r_bclk  <= w_c_n >= C_HALF;
            r_lrclk <= w_right;
            r_sdata <= w_sd;
            r_fs    <= w_bnd_n;
            r_ur    <= w_bnd_n && !w_full_n;
            r_full  <= w_full_n;
            if (w_acc) begin
                r_bufl <= sample_left;
                r_bufr <= sample_right;
            end
            if (w_bnd) begin
                r_fl <= r_full ? r_bufl : '0;
                r_fr <= r_full ? r_bufr : '0;
            end
        end
    end
endmodule

// File: tb/tb_i2s_transmitter.sv
// tb_i2s_transmitter: randomized bench against a cycle-index based reference model
module tb_i2s_transmitter;
    localparam int W   = 24;
    localparam int CPB = 6;
    localparam int S   = 32;
    localparam int F   = CPB * 2 * S;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] sample_left = '0, sample_right = '0;
    logic         sample_valid = 1'b0;
    logic         sample_ready, bclk, lrclk, sdata, frame_start, underrun;

    int           n_tests = 0, n_fail = 0;
    int           m_t = 0;
    logic         m_full = 1'b0;
    logic [W-1:0] m_bl = '0, m_br = '0, m_fl = '0, m_fr = '0;

    always #5 clk = ~clk;

    i2s_transmitter #(.AUDIO_BIT_WIDTH(W), .CLOCKS_PER_BIT(CPB), .SLOT_WIDTH(S)) dut (
        .clock(clk), .reset(reset), .sample_left(sample_left), .sample_right(sample_right),
        .sample_valid(sample_valid), .sample_ready(sample_ready), .bclk(bclk), .lrclk(lrclk),
        .sdata(sdata), .frame_start(frame_start), .underrun(underrun)
    );

    task automatic check(input string tag, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d got=%b exp=%b", tag, m_t, got, exp);
        end
    endtask

    function automatic logic exp_sdata(input int t);
        int b = (t / CPB) % (2 * S);
        int p = b % S;
        logic [W-1:0] ch = (b < S) ? m_fl : m_fr;
        return (p >= 1 && p <= W) ? ch[W-p] : 1'b0;
    endfunction

    task automatic tick(input logic rst_i, input logic v_i);
        logic         acc, bnd;
        logic [W-1:0] l, r;
        l = W'($urandom);
        r = W'($urandom);
        reset = rst_i;
        sample_valid = v_i;
        sample_left = l;
        sample_right = r;
        @(posedge clk);
        if (rst_i) begin
            m_t = 0;
            m_full = 1'b0;
            m_fl = '0;
            m_fr = '0;
        end else begin
            acc = v_i && !m_full;
            bnd = (m_t % F) == F - 1;
            if (bnd) begin
                m_fl = m_full ? m_bl : '0;
                m_fr = m_full ? m_br : '0;
                m_full = 1'b0;
            end
            if (acc) begin
                m_full = 1'b1;
                m_bl = l;
                m_br = r;
            end
            m_t++;
        end
        #1;
        check("bclk", bclk, (m_t % CPB) >= CPB / 2);
        check("lrclk", lrclk, ((m_t / CPB) % (2 * S)) >= S);
        check("sdata", sdata, exp_sdata(m_t));
        check("frame_start", frame_start, (m_t % F) == F - 1);
        check("underrun", underrun, ((m_t % F) == F - 1) && !m_full);
        check("sample_ready", sample_ready, !m_full);
    endtask

    initial begin
        #2;
        repeat (3) tick(1'b1, 1'b0);
        repeat (2 * F) tick(1'b0, 1'b0);
        repeat (4 * F) tick(1'b0, ($urandom % 4) == 0);
        repeat (4 * F) tick(1'b0, 1'b1);
        repeat (2 * F) tick(1'b0, 1'b0);
        repeat (3 * F) tick(1'b0, (m_t % F) == F - 1);
        repeat (2 * F) tick(1'b0, ($urandom % 64) == 0);
        tick(1'b0, 1'b1);
        while ((m_t % F) != 40 * CPB + 2) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        check("reset_ready", sample_ready, 1'b1);
        check("reset_sdata", sdata, 1'b0);
        repeat (2) tick(1'b1, 1'b1);
        repeat (3 * F) tick(1'b0, ($urandom % 8) == 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
